// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//
// Command-driven multi-mode shift register. A controller hands it a command
// over a valid/ready handshake. The block then performs a load, a clear, or a
// logical, arithmetic or rotate shift of one bit per clock for a programmable
// number of steps. It signals completion with a single-cycle done pulse.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   cmd_valid      command present
//   cmd_ready      command can be accepted (high while idle)
//   cmd_op         000 LOAD, 001 LSR, 010 LSL, 011 ASR, 100 ROR, 101 ROL,
//                  110 CLEAR, 111 reserved
//   cmd_count      number of one-bit steps for shift/rotate ops
//   load_data      value written by LOAD
//   serial_in_msb  fill bit entering the MSB on LSR (read live every step)
//   serial_in_lsb  fill bit entering the LSB on LSL (read live every step)
//   abort          cancels a running command, leaving the partial result
//   data_out       register contents
//   serial_out     last bit shifted or rotated out
//   busy           a multi-step command is running
//   done           one-cycle completion pulse
//   cmd_err        one-cycle pulse when a reserved op is accepted
// -----------------------------------------------------------------------------
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] load_data,
    input  logic             serial_in_msb,
    input  logic             serial_in_lsb,
    input  logic             abort,
    output logic [WIDTH-1:0] data_out,
    output logic             serial_out,
    output logic             busy,
    output logic             done,
    output logic             cmd_err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_LSR   = 3'b001;
    localparam logic [2:0] OP_LSL   = 3'b010;
    localparam logic [2:0] OP_ASR   = 3'b011;
    localparam logic [2:0] OP_ROR   = 3'b100;
    localparam logic [2:0] OP_ROL   = 3'b101;
    localparam logic [2:0] OP_CLEAR = 3'b110;
    localparam logic [2:0] OP_RSVD  = 3'b111;

    logic [0:0]       state;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] step_data;
    logic             step_out;

    // One single-bit step of a shift or rotate. The return value is
    // {bit shifted out, new register value}.
    function automatic logic [WIDTH:0] shift_step(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] d,
        input logic             msb_fill,
        input logic             lsb_fill
    );
        logic signed [WIDTH-1:0] ds;
        logic [WIDTH:0]          r;
        ds = d;
        case (op)
            OP_LSR:  r = {d[0],       msb_fill, d[WIDTH-1:1]};
            OP_LSL:  r = {d[WIDTH-1], d[WIDTH-2:0], lsb_fill};
            OP_ASR:  r = {d[0],       WIDTH'(ds >>> 1)};
            OP_ROR:  r = {d[0],       d[0], d[WIDTH-1:1]};
            OP_ROL:  r = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
            default: r = {1'b0, d};
        endcase
        return r;
    endfunction

    // The handshake and status outputs decode from state only. cmd_valid
    // therefore never reaches cmd_ready combinationally.
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state == S_RUN);

    always_comb begin
        {step_out, step_data} = shift_step(op_q, data_out, serial_in_msb, serial_in_lsb);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_q       <= OP_LOAD;
            cnt_q      <= '0;
            data_out   <= '0;
            serial_out <= 1'b0;
            done       <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            done    <= 1'b0;
            cmd_err <= 1'b0;
            if (state == S_IDLE) begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            data_out <= load_data;
                            done     <= 1'b1;
                        end
                        OP_CLEAR: begin
                            data_out <= '0;
                            done     <= 1'b1;
                        end
                        OP_RSVD: begin
                            done    <= 1'b1;
                            cmd_err <= 1'b1;
                        end
                        default: begin
                            // A zero-step shift finishes at once with no
                            // change to the data.
                            if (cmd_count == '0) begin
                                done <= 1'b1;
                            end else begin
                                op_q  <= cmd_op;
                                cnt_q <= cmd_count;
                                state <= S_RUN;
                            end
                        end
                    endcase
                end
            end else begin
                // abort takes priority over the step due on this edge. This
                // includes the final step, which also suppresses done.
                if (abort) begin
                    state <= S_IDLE;
                end else begin
                    data_out   <= step_data;
                    serial_out <= step_out;
                    cnt_q      <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] load_data;
    logic             serial_in_msb;
    logic             serial_in_lsb;
    logic             abort;
    logic [WIDTH-1:0] data_out;
    logic             serial_out;
    logic             busy;
    logic             done;
    logic             cmd_err;

    shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_count     (cmd_count),
        .load_data     (load_data),
        .serial_in_msb (serial_in_msb),
        .serial_in_lsb (serial_in_lsb),
        .abort         (abort),
        .data_out      (data_out),
        .serial_out    (serial_out),
        .busy          (busy),
        .done          (done),
        .cmd_err       (cmd_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The model tracks the register as an integer. It counts how many
    // steps remain in the running command.
    int   m_data;
    int   m_sout;
    int   m_done;
    int   m_err;
    int   m_rem;
    int   m_op;

    localparam int TOP  = 1 << (WIDTH - 1);
    localparam int FULL = 1 << WIDTH;

    task automatic model_step(input int op);
        int d;
        d = m_data;
        case (op)
            1: begin m_sout = d % 2;   d = d / 2 + (serial_in_msb ? TOP : 0); end
            2: begin m_sout = d / TOP; d = (d * 2) % FULL + int'(serial_in_lsb); end
            3: begin m_sout = d % 2;   d = d / 2 + ((d >= TOP) ? TOP : 0); end
            4: begin m_sout = d % 2;   d = d / 2 + (d % 2) * TOP; end
            5: begin m_sout = d / TOP; d = (d * 2) % FULL + d / TOP; end
            default: ;
        endcase
        m_data = d;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data = 0; m_sout = 0; m_done = 0; m_err = 0; m_rem = 0; m_op = 0;
        end else begin
            m_done = 0;
            m_err  = 0;
            if (m_rem > 0) begin
                if (abort) begin
                    m_rem = 0;
                end else begin
                    model_step(m_op);
                    m_rem--;
                    if (m_rem == 0) m_done = 1;
                end
            end else if (cmd_valid) begin
                case (int'(cmd_op))
                    0: begin m_data = int'(load_data); m_done = 1; end
                    6: begin m_data = 0; m_done = 1; end
                    7: begin m_done = 1; m_err = 1; end
                    default: begin
                        if (cmd_count == 0) m_done = 1;
                        else begin m_op = int'(cmd_op); m_rem = int'(cmd_count); end
                    end
                endcase
            end
        end
    end

    // The compare process checks every output against the model on each
    // falling edge while out of reset.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("cyc_data_out",  32'(data_out),   32'(m_data));
            chk("cyc_serial_out", 32'(serial_out), 32'(m_sout));
            chk("cyc_busy",      32'(busy),       32'(m_rem > 0));
            chk("cyc_cmd_ready", 32'(cmd_ready),  32'(m_rem == 0));
            chk("cyc_done",      32'(done),       32'(m_done));
            chk("cyc_cmd_err",   32'(cmd_err),    32'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [2:0] op, input int cnt, input logic [15:0] d);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = CNT_W'(cnt);
        load_data = d;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int bc);
        int n;
        n  = 0;
        bc = 0;
        while (done !== 1'b1 && n < 100) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            n++;
        end
        chk("done_within_bound", 32'(done), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_data_out"},  32'(data_out),   32'h0);
        chk({tag, "_serial_out"}, 32'(serial_out), 32'h0);
        chk({tag, "_busy"},      32'(busy),       32'h0);
        chk({tag, "_done"},      32'(done),       32'h0);
        chk({tag, "_cmd_err"},   32'(cmd_err),    32'h0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready),  32'h1);
    endtask

    int bc;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_count = '0; load_data = '0;
        serial_in_msb = 1'b0; serial_in_lsb = 1'b0; abort = 1'b0;
        #12;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // LOAD
        issue(3'b000, 0, 16'hA5C3);
        chk("load_data", 32'(data_out), 32'hA5C3);
        chk("load_done", 32'(done), 32'h1);
        chk("load_busy", 32'(busy), 32'h0);
        chk("model_load", 32'(m_data), 32'hA5C3);

        // ROR 4
        issue(3'b100, 4, 16'h0);
        wait_done(bc);
        chk("ror4_busy_cycles", 32'(bc), 32'd4);
        chk("ror4_data", 32'(data_out), 32'h3A5C);
        chk("ror4_sout", 32'(serial_out), 32'h0);
        chk("model_ror4", 32'(m_data), 32'h3A5C);
        @(negedge clk);
        chk("ror4_done_single", 32'(done), 32'h0);

        // ROL 4
        issue(3'b000, 0, 16'hA5C3);
        issue(3'b101, 4, 16'h0);
        wait_done(bc);
        chk("rol4_data", 32'(data_out), 32'h5C3A);
        chk("rol4_sout", 32'(serial_out), 32'h0);
        chk("model_rol4", 32'(m_data), 32'h5C3A);

        // ROR 20 wraps modulo WIDTH
        issue(3'b000, 0, 16'hA5C3);
        issue(3'b100, 20, 16'h0);
        wait_done(bc);
        chk("ror20_busy_cycles", 32'(bc), 32'd20);
        chk("ror20_data", 32'(data_out), 32'h3A5C);

        // ASR 3
        issue(3'b000, 0, 16'h8000);
        issue(3'b011, 3, 16'h0);
        wait_done(bc);
        chk("asr3_data", 32'(data_out), 32'hF000);
        chk("asr3_sout", 32'(serial_out), 32'h0);
        chk("model_asr3", 32'(m_data), 32'hF000);

        // LSL 16
        issue(3'b000, 0, 16'hFFFF);
        serial_in_lsb = 1'b0;
        issue(3'b010, 16, 16'h0);
        wait_done(bc);
        chk("lsl16_data", 32'(data_out), 32'h0000);
        chk("lsl16_sout", 32'(serial_out), 32'h1);

        // CLEAR leaves serial_out alone
        issue(3'b000, 0, 16'h1234);
        issue(3'b110, 0, 16'h0);
        chk("clear_data", 32'(data_out), 32'h0);
        chk("clear_sout", 32'(serial_out), 32'h1);
        chk("clear_done", 32'(done), 32'h1);

        // LSR with a live fill of 1
        serial_in_msb = 1'b1;
        issue(3'b001, 4, 16'h0);
        wait_done(bc);
        chk("lsr_fill1_data", 32'(data_out), 32'hF000);
        chk("lsr_fill1_sout", 32'(serial_out), 32'h0);
        serial_in_msb = 1'b0;

        // LSR 8 aborted after 3 steps
        issue(3'b000, 0, 16'hFF00);
        issue(3'b001, 8, 16'h0);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_data", 32'(data_out), 32'h1FE0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_ready", 32'(cmd_ready), 32'h1);
        chk("abort_no_done", 32'(done), 32'h0);
        chk("model_abort", 32'(m_data), 32'h1FE0);
        repeat (3) @(negedge clk);
        chk("abort_still_no_done", 32'(done), 32'h0);

        // abort in IDLE is ignored
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_data", 32'(data_out), 32'h1FE0);

        // Reserved op
        issue(3'b111, 0, 16'h0);
        chk("rsvd_done", 32'(done), 32'h1);
        chk("rsvd_err", 32'(cmd_err), 32'h1);
        chk("rsvd_data", 32'(data_out), 32'h1FE0);

        // ROR with a count of zero
        issue(3'b100, 0, 16'h0);
        chk("ror0_done", 32'(done), 32'h1);
        chk("ror0_err", 32'(cmd_err), 32'h0);
        chk("ror0_data", 32'(data_out), 32'h1FE0);

        // Async reset in the middle of ROL 10
        issue(3'b000, 0, 16'h1234);
        issue(3'b101, 10, 16'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        chk("post_reset_ready", 32'(cmd_ready), 32'h1);
        issue(3'b000, 0, 16'hBEEF);
        chk("post_reset_load", 32'(data_out), 32'hBEEF);
        chk("post_reset_done", 32'(done), 32'h1);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
